round_sequencer: RTL

Control-side partner of the permutation round counting in the ASCON core. Accepts a permutation request carrying a round count (12 for p^a, 6 or 8 for p^b), then issues one round-enable per cycle to the permutation datapath with the matching round constant and first/last flags. It absorbs datapath stalls and reports completion through a valid/ready handshake to the mode FSM.

---
 rtl/round_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Round sequencer for the ASCON permutation: steps n rounds with constants and first/last flags.
// Optional ROUND_SEQ_ABORT_EN adds an abort input that cancels a running or completed request.
module round_sequencer #(
    parameter int unsigned MAX_ROUNDS = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [3:0] nrounds,
    input  logic       stall,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [7:0] rc,
    output logic       round_first,
    output logic       round_last,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
`ifdef ROUND_SEQ_ABORT_EN
    ,
    input  logic       abort
`endif
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] n_clamp;
    logic [CNT_W-1:0] rc_i;
    logic             done_d;
    logic             busy_d;
    logic             abort_c;
    logic             at_last_c;

`ifdef ROUND_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Out-of-range round counts fall back to the full permutation
    assign n_clamp = ((nrounds == '0) || (nrounds > CNT_W'(MAX_ROUNDS)))
                     ? CNT_W'(MAX_ROUNDS) : nrounds;

    assign start_ready = (state_q == IDLE);
    assign round_en    = (state_q == RUN) && !stall;
    assign at_last_c   = (round_idx == n_q - CNT_W'(1));
    assign round_first = round_en && (round_idx == '0);
    assign round_last  = round_en && at_last_c;

    // Constant index offsets short permutations onto the tail of the 12-round schedule
    assign rc_i = CNT_W'(MAX_ROUNDS) - n_q + round_idx;
    assign rc   = (state_q == RUN) ? {~rc_i, rc_i} : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            round_idx  <= '0;
            n_q        <= CNT_W'(MAX_ROUNDS);
            done_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_idx  <= idx_d;
            n_q        <= n_d;
            done_valid <= done_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = round_idx;
        n_d     = n_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    n_d     = n_clamp;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    idx_d = round_idx + CNT_W'(1);
                    if (at_last_c) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every other transition once a request is in flight
        if (abort_c && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
        end

        done_d = (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

endmodule
